// File: rtl/i4001_bus_if.sv
// Bus-side front end for a 4001 program ROM: decodes the eight-phase 4004 cycle,
// addresses a 128x16 memory from A1/A2, returns OPR/OPA in M1/M2, and arbitrates a loader port.
module i4001_bus_if #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync,
  input  logic [3:0]  d_in,
  output logic [3:0]  d_out,
  output logic        d_oe,
  input  logic        ld_valid,
  input  logic [6:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  output logic [6:0]  mem_address,
  output logic        mem_we,
  output logic [15:0] mem_in,
  input  logic [15:0] mem_out
);

  localparam int unsigned NW = 4;
  localparam int unsigned AW = 7;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_A1   = 4'd1,
    S_A2   = 4'd2,
    S_A3   = 4'd3,
    S_M1   = 4'd4,
    S_M2   = 4'd5,
    S_X1   = 4'd6,
    S_X2   = 4'd7,
    S_X3   = 4'd8
  } state_t;

  state_t          state;
  logic [NW-1:0]   a1;
  logic [NW-1:0]   a2;
  logic [NW-1:0]   a3;
  logic [NW-1:0]   opa_q;
  logic            cs;
  logic [7:0]      sel_byte;
  logic            ld_fire;

  // Chip select follows the captured A3 nibble; only looked at in M1/M2.
  assign cs = (a3 == CHIP_ID);

  // Even byte lives in the upper half of the word.
  assign sel_byte = a1[0] ? mem_out[7:0] : mem_out[15:8];

  // Phase sequencer plus address capture and OPA latch; SYNC always restarts at A1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a1    <= '0;
      a2    <= '0;
      a3    <= '0;
      opa_q <= '0;
    end else begin
      case (state)
        S_A1:    a1 <= d_in;
        S_A2:    a2 <= d_in;
        S_A3:    a3 <= d_in;
        S_M1:    if (!sync) opa_q <= sel_byte[3:0];
        default: ;
      endcase
      if (sync) begin
        state <= S_A1;
      end else begin
        case (state)
          S_A1:    state <= S_A2;
          S_A2:    state <= S_A3;
          S_A3:    state <= S_M1;
          S_M1:    state <= S_M2;
          S_M2:    state <= S_X1;
          S_X1:    state <= S_X2;
          S_X2:    state <= S_X3;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // The A3 and M1 edges belong to the bus read, so the loader is held off there.
  assign ld_ready    = (state != S_A3) && (state != S_M1);
  assign ld_fire     = ld_valid && ld_ready && rst_n;
  assign mem_we      = ld_fire;
  assign mem_in      = ld_data;
  assign mem_address = ld_fire ? ld_addr : AW'({a2, a1[3:1]});

  // Bus drive decode; OPR straight from memory in M1, OPA from the latch in M2.
  always_comb begin
    d_oe  = 1'b0;
    d_out = '0;
    case (state)
      S_M1: begin
        d_oe = cs;
        if (cs) d_out = sel_byte[7:4];
      end
      S_M2: begin
        d_oe = cs;
        if (cs) d_out = opa_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i4001_bus_if.sv
// Randomized scoreboard bench for i4001_bus_if with a behavioural 128x16 memory behind it.
module tb_i4001_bus_if;

  localparam logic [3:0] CHIP = 4'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync = 1'b0;
  logic [3:0]  d_in = '0;
  logic [3:0]  d_out;
  logic        d_oe;
  logic        ld_valid = 1'b0;
  logic [6:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic [6:0]  mem_address;
  logic        mem_we;
  logic [15:0] mem_in;
  logic [15:0] mem_out;

  int checks = 0;
  int errors = 0;
  logic [3:0]  exp_q[$];
  logic [15:0] ram[128];
  logic [15:0] model[128];
  logic [3:0]  mon_e;
  bit          in_a1 = 1'b0;

  i4001_bus_if #(.CHIP_ID(CHIP)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_address(mem_address), .mem_we(mem_we), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Block RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) ram[mem_address] <= mem_in;
    mem_out <= ram[mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every driven nibble must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (d_oe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_drive: got d_out %0h expected no drive at %0t", d_out, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_nibble", d_out, mon_e);
        end
      end else begin
        chk("d_out_quiet", d_out, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [6:0] addr, input logic [15:0] data);
    int n = 0;
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    #1;
    while (!ld_ready && n < 20) begin
      step();
      n++;
    end
    if (!ld_ready) begin
      chk("ld_timeout", 0, 1);
    end else begin
      chk("ld_we", mem_we, 1);
      chk("ld_addr_mux", mem_address, addr);
      model[addr] = data;
    end
    step();
    ld_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sync = 1'b0;
      #1;
      chk("idle_ready", ld_ready, 1);
      chk("idle_doe", d_oe, 0);
      step();
    end
  endtask

  // One bus instruction cycle. abort: 1 = SYNC in M1, 2 = SYNC in M2.
  // ld_p: cycle index (1..8) at which a loader write is raised, 0 = none.
  task automatic fetch(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                       input int abort, input bit skip_sync, input int ld_p,
                       input logic [6:0] la, input logic [15:0] ldd, input bit rst_m2);
    int baddr = int'(a2) * 16 + int'(a1);
    int word = baddr / 2;
    bit odd = (baddr % 2) == 1;
    bit hit = (a3 == CHIP);
    bit pend = 1'b0;
    bit done = 1'b0;
    logic [15:0] w;
    logic [7:0] byt = '0;
    for (int p = (skip_sync ? 1 : 0); p <= 8; p++) begin
      sync = (p == 0) || (abort == 1 && p == 4) || (abort == 2 && p == 5);
      d_in = (p == 1) ? a1 : (p == 2) ? a2 : (p == 3) ? a3 : 4'($urandom);
      if (ld_p != 0 && p == ld_p) begin
        ld_valid = 1'b1;
        ld_addr  = la;
        ld_data  = ldd;
        pend     = 1'b1;
      end
      #1;
      if (p == 1) chk("a1_doe", d_oe, 0);
      if (p == 3) begin
        chk("a3_ready", ld_ready, 0);
        chk("a3_no_we", mem_we, 0);
        chk("a3_addr", mem_address, 32'(word));
      end
      if (p == 4) begin
        chk("m1_ready", ld_ready, 0);
        chk("m1_no_we", mem_we, 0);
        if (hit) begin
          w = model[word];
          byt = odd ? w[7:0] : w[15:8];
          exp_q.push_back(byt[7:4]);
        end
      end
      if (p == 5 && hit && abort != 1 && !rst_m2) exp_q.push_back(byt[3:0]);
      if (pend && ld_ready) begin
        chk("ld_accept_phase", 32'(p), 32'((ld_p == 3 || ld_p == 4) ? 5 : ld_p));
        chk("ld_fire_we", mem_we, 1);
        chk("ld_fire_addr", mem_address, la);
        model[la] = ldd;
        pend = 1'b0;
        done = 1'b1;
      end
      if (p == 5 && rst_m2) begin
        rst_n = 1'b0;
        #1;
        chk("rst_doe", d_oe, 0);
        chk("rst_dout", d_out, 0);
        chk("rst_we", mem_we, 0);
        step();
        rst_n = 1'b1;
        sync = 1'b0;
        #1;
        chk("rst_ready", ld_ready, 1);
        return;
      end
      step();
      if (done) begin
        ld_valid = 1'b0;
        done = 1'b0;
      end
      if ((abort == 1 && p == 4) || (abort == 2 && p == 5)) begin
        sync = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int abort;
    int ld_p;
    logic [3:0] a3r;
    for (int i = 0; i < 128; i++) model[i] = '0;

    // Reset with a loader request pending: nothing may be written.
    ld_valid = 1'b1;
    ld_addr  = 7'h11;
    ld_data  = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_doe", d_oe, 0);
    chk("reset_dout", d_out, 0);
    chk("reset_we", mem_we, 0);
    ld_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", ld_ready, 1);
    idle(3);

    for (int i = 0; i < 128; i++) load_word(7'(i), 16'($urandom));
    load_word(7'h52, 16'hA3C7);
    load_word(7'h00, 16'h1234);

    fetch(4'h5, 4'hA, 4'h0, 0, 0, 0, '0, '0, 0);
    fetch(4'h4, 4'hA, 4'h0, 0, 0, 0, '0, '0, 0);
    fetch(4'h4, 4'hA, 4'h1, 0, 0, 0, '0, '0, 0);
    fetch(4'h5, 4'hA, 4'h0, 0, 0, 2, 7'h52, 16'h9999, 0);
    fetch(4'h5, 4'hA, 4'h0, 0, 0, 3, 7'h52, 16'h5A5A, 0);
    fetch(4'h4, 4'hA, 4'h0, 0, 0, 0, '0, '0, 0);
    fetch(4'h5, 4'hA, 4'h0, 1, 0, 0, '0, '0, 0);
    fetch(4'h0, 4'h0, 4'h0, 0, 1, 0, '0, '0, 0);
    fetch(4'h5, 4'hA, 4'h0, 2, 0, 0, '0, '0, 0);
    fetch(4'h1, 4'h0, 4'h0, 0, 1, 0, '0, '0, 0);
    idle(2);
    fetch(4'h5, 4'hA, 4'h0, 0, 0, 0, '0, '0, 1);
    idle(10);

    for (int it = 0; it < 80; it++) begin
      if (!in_a1 && ($urandom % 3 == 0)) load_word(7'($urandom), 16'($urandom));
      a3r = ($urandom % 4 == 0) ? 4'($urandom) : CHIP;
      case ($urandom % 6)
        0: abort = 1;
        1: abort = 2;
        default: abort = 0;
      endcase
      ld_p = 0;
      if ($urandom % 3 == 0)
        ld_p = (abort == 1) ? int'($urandom_range(1, 2))
             : (abort == 2) ? int'($urandom_range(1, 5))
             : int'($urandom_range(1, 8));
      fetch(4'($urandom), 4'($urandom), a3r, abort, in_a1, ld_p,
            7'($urandom), 16'($urandom), 0);
      in_a1 = (abort != 0);
    end
    if (in_a1) fetch(4'h3, 4'h7, CHIP, 0, 1, 0, '0, '0, 0);
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
